// File: rtl/cpu_wb_seq_multiplier.sv
// Iterative shift-add multiplier for the writeback stage.
// Retires STEP_BITS multiplier bits per cycle, with valid/ready handshakes on both sides.
module cpu_wb_seq_multiplier #(
  parameter int MULTICAND_WID  = 32,
  parameter int MULTIPLIER_WID = 32,
  parameter int STEP_BITS      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [MULTICAND_WID-1:0]                multicand,
  input  logic [MULTIPLIER_WID-1:0]               multiplier,
  input  logic                                    is_signed,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product,
  output logic                                    busy
);

  localparam int ITER     = MULTIPLIER_WID / STEP_BITS;
  localparam int PROD_WID = MULTICAND_WID + MULTIPLIER_WID;
  localparam int CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;

  if (MULTIPLIER_WID % STEP_BITS != 0) begin : g_step_check
    $error("STEP_BITS must evenly divide MULTIPLIER_WID");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PROD_WID-1:0]   r_acc;
  logic [PROD_WID-1:0]   r_mag_a;
  logic [MULTIPLIER_WID-1:0] r_mplr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg;
  logic [PROD_WID-1:0]   r_product;

  logic                      w_a_neg;
  logic                      w_b_neg;
  logic [MULTICAND_WID-1:0]  w_mag_a;
  logic [MULTIPLIER_WID-1:0] w_mag_b;
  logic [PROD_WID-1:0]       w_pp;
  logic [PROD_WID-1:0]       w_acc_nxt;
  logic [PROD_WID-1:0]       w_result;
  logic                      w_last;

  // Magnitudes stay unsigned at full width, so negating the most negative value is exact.
  assign w_a_neg = is_signed & multicand[MULTICAND_WID-1];
  assign w_b_neg = is_signed & multiplier[MULTIPLIER_WID-1];
  assign w_mag_a = w_a_neg ? -multicand : multicand;
  assign w_mag_b = w_b_neg ? -multiplier : multiplier;

  // r_mag_a is pre-shifted each step, so the partial product lands already aligned.
  assign w_pp      = r_mag_a * PROD_WID'(r_mplr[STEP_BITS-1:0]);
  assign w_acc_nxt = r_acc + w_pp;
  assign w_result  = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_last    = (r_cnt == CNT_W'(ITER - 1));

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mag_a   <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mag_a <= PROD_WID'(w_mag_a);
            r_mplr  <= w_mag_b;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_mag_a <= r_mag_a << STEP_BITS;
          r_mplr  <= r_mplr >> STEP_BITS;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_product <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign product   = r_product;

endmodule

// File: tb/tb_cpu_wb_seq_multiplier.sv
// Self-checking bench: directed 32x32 cases plus a randomized 8x12 sweep
// against a plain-arithmetic reference model.
module tb_cpu_wb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-parameter instance (32x32, STEP_BITS=4, ITER=8).
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_mcand = '0;
  logic [31:0] a_mplr = '0;
  logic        a_signed = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [63:0] a_product;
  logic        a_busy;

  // Sweep instance (8x12, STEP_BITS=3, ITER=4).
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_mcand = '0;
  logic [11:0] b_mplr = '0;
  logic        b_signed = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [19:0] b_product;
  logic        b_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_wb_seq_multiplier u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .multicand  (a_mcand),
    .multiplier (a_mplr),
    .is_signed  (a_signed),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .product    (a_product),
    .busy       (a_busy)
  );

  cpu_wb_seq_multiplier #(
    .MULTICAND_WID  (8),
    .MULTIPLIER_WID (12),
    .STEP_BITS      (3)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .multicand  (b_mcand),
    .multiplier (b_mplr),
    .is_signed  (b_signed),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .product    (b_product),
    .busy       (b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sign-extend to 64 bits, multiply modulo 2^64, keep the product width.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int wa, input int wb);
    logic [63:0] xa, xb, p;
    xa = a;
    xb = b;
    if (s && a[wa-1]) xa = a | (~64'd0 << wa);
    if (s && b[wb-1]) xb = b | (~64'd0 << wb);
    p = xa * xb;
    if (wa + wb < 64) p = p & ((64'd1 << (wa + wb)) - 64'd1);
    return p;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [63:0] exp, input int hold, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
    a_in_valid  = 1'b1;
    a_mcand     = a;
    a_mplr      = b;
    a_signed    = s;
    a_out_ready = (hold == 0);
    @(posedge clk); #1;
    check({tag, "_busy"}, 64'(a_busy), 64'd1);
    // New operands during BUSY/DONE must be ignored.
    a_mcand = $urandom;
    a_mplr  = $urandom;
    a_signed = ~s;
    n = 0;
    while (!a_out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd8);
    check({tag, "_prod"}, a_product, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ov"}, 64'(a_out_valid), 64'd1);
      check({tag, "_hold_rdy"}, 64'(a_in_ready), 64'd0);
      check({tag, "_hold_prod"}, a_product, exp);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ov"}, 64'(a_out_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b0;
  endtask

  task automatic sweep_op(input logic [7:0] a, input logic [11:0] b, input bit s);
    logic [63:0] exp;
    int n;
    int k;
    bit hs;
    exp = ref_mul(64'(a), 64'(b), s, 8, 12);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    check("sw_rdy", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1;
    b_mcand    = a;
    b_mplr     = b;
    b_signed   = s;
    @(posedge clk); #1;
    check("sw_busy", 64'(b_busy), 64'd1);
    b_in_valid  = 1'($urandom_range(0, 1));
    b_mcand     = 8'($urandom);
    b_mplr      = 12'($urandom);
    b_signed    = 1'($urandom_range(0, 1));
    b_out_ready = 1'($urandom_range(0, 1));
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      b_out_ready = 1'($urandom_range(0, 1));
    end
    check("sw_lat", 64'(n), 64'd4);
    k  = 0;
    hs = 1'b0;
    while (!hs) begin
      check("sw_prod", 64'(b_product), exp);
      check("sw_ov", 64'(b_out_valid), 64'd1);
      hs = b_out_ready;
      @(posedge clk); #1;
      k++;
      if (!hs) b_out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    check("sw_ov_low", 64'(b_out_valid), 64'd0);
    b_in_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    logic [7:0]  sa;
    logic [11:0] sb;

    #2;
    check("rst_a_rdy", 64'(a_in_ready), 64'd1);
    check("rst_a_ov", 64'(a_out_valid), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_prod", a_product, 64'd0);
    check("rst_b_rdy", 64'(b_in_ready), 64'd1);
    check("rst_b_prod", 64'(b_product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F, 0, "u_small");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "u_max");
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, "s_neg");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 5, "s_min_bp");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, ref_mul(64'(ra), 64'(rb), rs, 32, 32), $urandom_range(0, 2), "rnd32");
    end

    // Abort in flight: reset lands between edges after three BUSY steps.
    @(negedge clk);
    a_in_valid = 1'b1;
    a_mcand    = 32'h0000_1234;
    a_mplr     = 32'h0000_5678;
    a_signed   = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(a_busy), 64'd0);
    check("arst_rdy", 64'(a_in_ready), 64'd1);
    check("arst_ov", 64'(a_out_valid), 64'd0);
    check("arst_prod", a_product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd2, 1'b0, 64'd4, 0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      sa = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      sb = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom);
      rs = 1'($urandom_range(0, 1));
      sweep_op(sa, sb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
